// File: rtl/book_event_mux.sv
// book_event_mux: merges per-channel ITCH book events into one valid/ready stream.
// Optional BOOK_EVT_DROP_CNT_EN builds saturating 16-bit per-channel drop counters.
module book_event_mux #(
  parameter int N_CH   = 2,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 177
) (
  input  logic                     clkIn,
  input  logic                     rstBIn,
  input  logic                     flushIn,
  input  logic [N_CH-1:0]          chValidIn,
  input  logic [2*N_CH-1:0]        chTypeIn,
  input  logic [N_CH*DATA_W-1:0]   chDataIn,
  output logic                     outValidOut,
  input  logic                     outReadyIn,
  output logic [1:0]               outTypeOut,
  output logic [$clog2(N_CH)-1:0]  outChOut,
  output logic [DATA_W-1:0]        outDataOut,
  output logic                     overflowOut,
  output logic [16*N_CH-1:0]       dropCntOut
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(N_CH);
  localparam int CNTW = PW + 1;
  localparam int EW   = DATA_W + 2;

  logic [N_CH-1:0]    empty;
  logic [N_CH-1:0]    pop;
  logic [N_CH-1:0]    drop;
  logic [N_CH*EW-1:0] headFlat;
  logic [CW-1:0]      lastGrant;
  logic [CW-1:0]      grantCh;
  logic [CW-1:0]      cand;
  logic               grantVld;
  logic               loadable;
  logic               doGrant;

  assign loadable = !outValidOut || outReadyIn;
  assign doGrant  = grantVld && loadable && !flushIn;

  // Round-robin pick: scan far-to-near so the channel right after lastGrant wins.
  always_comb begin
    grantVld = 1'b0;
    grantCh  = '0;
    cand     = '0;
    for (int k = N_CH; k >= 1; k--) begin
      cand = CW'((int'(lastGrant) + k) % N_CH);
      if (!empty[cand]) begin
        grantVld = 1'b1;
        grantCh  = cand;
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : gCh
    logic [EW-1:0]   mem [DEPTH];
    logic [PW-1:0]   rdPtr;
    logic [PW-1:0]   wrPtr;
    logic [CNTW-1:0] count;
    logic            legal;
    logic            full;
    logic            wrEn;

    assign legal = chValidIn[i] && (chTypeIn[2*i +: 2] != 2'b00) && !flushIn;
    assign full  = (count == CNTW'(DEPTH));
    assign pop[i]  = doGrant && (grantCh == CW'(i));
    assign wrEn    = legal && (!full || pop[i]);
    assign drop[i] = legal && full && !pop[i];
    assign empty[i] = (count == '0);
    assign headFlat[i*EW +: EW] = mem[rdPtr];

    // Event storage; type travels with the payload.
    always_ff @(posedge clkIn) begin
      if (wrEn) begin
        mem[wrPtr] <= {chTypeIn[2*i +: 2], chDataIn[i*DATA_W +: DATA_W]};
      end
    end

    // FIFO pointers and occupancy; flush empties the queue.
    always_ff @(posedge clkIn or negedge rstBIn) begin
      if (!rstBIn) begin
        rdPtr <= '0;
        wrPtr <= '0;
        count <= '0;
      end else if (flushIn) begin
        rdPtr <= '0;
        wrPtr <= '0;
        count <= '0;
      end else begin
        if (wrEn) wrPtr <= wrPtr + PW'(1);
        if (pop[i]) rdPtr <= rdPtr + PW'(1);
        count <= count + CNTW'(wrEn) - CNTW'(pop[i]);
      end
    end

`ifdef BOOK_EVT_DROP_CNT_EN
    logic [15:0] dropCnt;

    // Saturating drop counter; survives flush.
    always_ff @(posedge clkIn or negedge rstBIn) begin
      if (!rstBIn) begin
        dropCnt <= '0;
      end else if (drop[i] && (dropCnt != 16'hFFFF)) begin
        dropCnt <= dropCnt + 16'd1;
      end
    end

    assign dropCntOut[16*i +: 16] = dropCnt;
`else
    assign dropCntOut[16*i +: 16] = 16'h0;
`endif
  end

  // Output register and arbiter state; holds while stalled.
  always_ff @(posedge clkIn or negedge rstBIn) begin
    if (!rstBIn) begin
      outValidOut <= 1'b0;
      outTypeOut  <= '0;
      outChOut    <= '0;
      outDataOut  <= '0;
      lastGrant   <= CW'(N_CH - 1);
    end else if (flushIn) begin
      outValidOut <= 1'b0;
    end else if (loadable) begin
      outValidOut <= grantVld;
      if (grantVld) begin
        {outTypeOut, outDataOut} <= headFlat[grantCh*EW +: EW];
        outChOut  <= grantCh;
        lastGrant <= grantCh;
      end
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clkIn or negedge rstBIn) begin
    if (!rstBIn) begin
      overflowOut <= 1'b0;
    end else if (|drop) begin
      overflowOut <= 1'b1;
    end
  end

endmodule

// File: tb/tb_book_event_mux.sv
// tb_book_event_mux: scoreboard bench for book_event_mux.
// Honors BOOK_EVT_DROP_CNT_EN for drop counter expectations.
module tb_book_event_mux;

  localparam int N_CH   = 2;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 177;
`ifdef BOOK_EVT_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]        t;
    logic              ch;
    logic [DATA_W-1:0] d;
  } ev_t;

  logic                   clk = 1'b0;
  logic                   rstB = 1'b1;
  logic                   flush = 1'b0;
  logic [N_CH-1:0]        chValid = '0;
  logic [2*N_CH-1:0]      chType = '0;
  logic [N_CH*DATA_W-1:0] chData = '0;
  logic                   outValid;
  logic                   outReady = 1'b1;
  logic [1:0]             outType;
  logic [0:0]             outCh;
  logic [DATA_W-1:0]      outData;
  logic                   overflow;
  logic [16*N_CH-1:0]     dropCnt;

  int  total = 0;
  int  bad = 0;
  int  rxCnt = 0;
  int  base;
  ev_t expQ[$];
  ev_t e;

  always #2 clk = ~clk;

  book_event_mux #(.N_CH(N_CH), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clkIn(clk),
    .rstBIn(rstB),
    .flushIn(flush),
    .chValidIn(chValid),
    .chTypeIn(chType),
    .chDataIn(chData),
    .outValidOut(outValid),
    .outReadyIn(outReady),
    .outTypeOut(outType),
    .outChOut(outCh),
    .outDataOut(outData),
    .overflowOut(overflow),
    .dropCntOut(dropCnt)
  );

  task automatic chk(string tag, logic [191:0] got, logic [191:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [DATA_W-1:0] pay(int n);
    pay = {1'b1, 48'(n), 64'hDEAD_BEEF_0000_0000 | 64'(n), 64'(n * 3)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setCh(int ch, logic [1:0] t, logic [DATA_W-1:0] d);
    chValid[ch] = 1'b1;
    chType[2*ch +: 2] = t;
    chData[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic clrAll();
    chValid = '0;
    chType = '0;
    chData = '0;
  endtask

  task automatic pushExp(int ch, logic [1:0] t, logic [DATA_W-1:0] d);
    ev_t x;
    x.t = t;
    x.ch = ch[0];
    x.d = d;
    expQ.push_back(x);
  endtask

  task automatic doReset();
    chk("leftover_exp", 192'(expQ.size()), 0);
    expQ.delete();
    rstB = 1'b0;
    flush = 1'b0;
    outReady = 1'b1;
    clrAll();
    repeat (2) @(posedge clk);
    #1;
    rstB = 1'b1;
  endtask

  // Scoreboard: every handshake must match the next expected event.
  always @(negedge clk) begin
    if (rstB && outValid && outReady) begin
      if (expQ.size() == 0) begin
        chk("unexpected_out", {outType, outCh, outData}, 0);
      end else begin
        e = expQ.pop_front();
        chk("out_type", outType, e.t);
        chk("out_ch", outCh, e.ch);
        chk("out_data", outData, e.d);
      end
      rxCnt++;
    end
  end

  initial begin
    // reset state
    #1 rstB = 1'b0;
    #2;
    chk("rst_valid", outValid, 0);
    chk("rst_type", outType, 0);
    chk("rst_ch", outCh, 0);
    chk("rst_data", outData, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", dropCnt, 0);
    doReset();

    // single add, latency 2
    setCh(0, 2'b01, 177'h1);
    pushExp(0, 2'b01, 177'h1);
    step();
    clrAll();
    @(negedge clk);
    chk("lat_k", outValid, 0);
    step();
    chk("lat_k1", outValid, 1);
    step();
    chk("lat_k2", outValid, 0);

    // simultaneous arrivals, round robin
    doReset();
    base = rxCnt;
    for (int c = 0; c < 3; c++) begin
      setCh(0, 2'b01, pay(10 + c));
      setCh(1, 2'b10, pay(20 + c));
      pushExp(0, 2'b01, pay(10 + c));
      pushExp(1, 2'b10, pay(20 + c));
      step();
    end
    clrAll();
    repeat (4) step();
    chk("rr_cnt5", 192'(rxCnt - base), 5);
    step();
    chk("rr_cnt6", 192'(rxCnt - base), 6);
    chk("rr_idle", outValid, 0);

    // overflow on ch1 with ready low
    doReset();
    outReady = 1'b0;
    base = rxCnt;
    for (int j = 0; j < 6; j++) begin
      setCh(1, 2'b11, pay(100 + j));
      if (j < 5) pushExp(1, 2'b11, pay(100 + j));
      step();
    end
    setCh(1, 2'b00, pay(200));
    step();
    clrAll();
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop1", dropCnt[16 +: 16], CNT_EN ? 1 : 0);
    chk("ovf_drop0", dropCnt[0 +: 16], 0);
    chk("ovf_hold_v", outValid, 1);
    chk("ovf_hold_d", outData, pay(100));
    outReady = 1'b1;
    repeat (8) step();
    chk("ovf_drain", 192'(rxCnt - base), 5);
    chk("ovf_sticky", overflow, 1);

    // output stability under backpressure
    doReset();
    outReady = 1'b0;
    base = rxCnt;
    setCh(0, 2'b10, pay(77));
    pushExp(0, 2'b10, pay(77));
    step();
    clrAll();
    step();
    for (int j = 0; j < 10; j++) begin
      chk("hold_v", outValid, 1);
      chk("hold_t", outType, 2'b10);
      chk("hold_c", outCh, 0);
      chk("hold_d", outData, pay(77));
      step();
    end
    outReady = 1'b1;
    repeat (4) step();
    chk("hold_once", 192'(rxCnt - base), 1);
    chk("hold_idle", outValid, 0);

    // flush with same-cycle write
    doReset();
    outReady = 1'b0;
    base = rxCnt;
    for (int j = 0; j < 3; j++) begin
      setCh(1, 2'b01, pay(300 + j));
      step();
    end
    clrAll();
    flush = 1'b1;
    setCh(0, 2'b01, pay(99));
    step();
    flush = 1'b0;
    clrAll();
    chk("fl_valid", outValid, 0);
    outReady = 1'b1;
    repeat (5) step();
    chk("fl_none", 192'(rxCnt - base), 0);
    chk("fl_drop", dropCnt, 0);
    chk("fl_ovf", overflow, 0);
    setCh(0, 2'b01, pay(55));
    pushExp(0, 2'b01, pay(55));
    step();
    clrAll();
    repeat (3) step();
    chk("fl_after", 192'(rxCnt - base), 1);

    // illegal type ignored
    doReset();
    base = rxCnt;
    setCh(0, 2'b00, pay(5));
    step();
    clrAll();
    repeat (3) step();
    chk("ill_none", 192'(rxCnt - base), 0);
    chk("ill_ovf", overflow, 0);

    // drop counter saturation on ch0
    doReset();
    outReady = 1'b0;
    base = rxCnt;
    for (int j = 0; j < 5; j++) pushExp(0, 2'b01, pay(7));
    setCh(0, 2'b01, pay(7));
    for (int j = 1; j <= 70005; j++) begin
      step();
      if (j == 1000) chk("sat_mid", dropCnt[0 +: 16], CNT_EN ? 995 : 0);
    end
    clrAll();
    chk("sat_full", dropCnt[0 +: 16], CNT_EN ? 16'hFFFF : 0);
    chk("sat_ch1", dropCnt[16 +: 16], 0);
    outReady = 1'b1;
    repeat (10) step();
    chk("sat_drain", 192'(rxCnt - base), 5);
    chk("end_exp", 192'(expQ.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/book_event_mux.md
# book_event_mux

Merges parsed order-book events (add / delete / execute) from N_CH independent ITCH parser channels into a single valid/ready event stream for the order-book engine, in the 250 MHz domain. Each channel has a small FIFO because the parsers cannot be stalled. A round-robin arbiter drains the FIFOs into one registered output stage. Overflow is detected per channel and never corrupts queued events.

## Interface
Parameters:
- N_CH, 2: number of input channels (≥2).
- DEPTH, 4: per-channel FIFO depth in entries (power of 2, ≥2).
- DATA_W, 177: event payload width (refNum 64 + locate 16 + price 32 + shares 64 + buySell 1).

Ports:
- clkIn  in  1  single clock for the block (clk250).
- rstBIn  in  1  asynchronous, active-low reset.
- flushIn  in  1  synchronous clear of all FIFOs (driven from packetLost).
- chValidIn  in  N_CH  per-channel event strobe; no backpressure.
- chTypeIn  in  2*N_CH  per-channel type: 01 add, 10 del, 11 exec, 00 illegal.
- chDataIn  in  N_CH*DATA_W  per-channel payload; channel i at [i*DATA_W +: DATA_W].
- outValidOut  out  1  output event valid.
- outReadyIn  in  1  consumer accepts the event when high with outValidOut.
- outTypeOut  out  2  type of the output event.
- outChOut  out  $clog2(N_CH)  source channel of the output event.
- outDataOut  out  DATA_W  payload of the output event.
- overflowOut  out  1  sticky; set on any drop; cleared only by reset.
- dropCntOut  out  16*N_CH  per-channel drop counters (see Configuration).

## Operation
- Write: a channel write is accepted when chValidIn[i]=1, type≠00, and either count<DEPTH or count==DEPTH with channel i popped in the same cycle.
- Illegal type: chValidIn with type 00 is ignored. It is not stored and not counted as a drop.
- Drop: a legal event arriving at a full FIFO with no same-cycle pop is discarded. overflowOut is set and the drop counter increments. Queued entries are untouched.
- Arbitration: round-robin over non-empty FIFOs. The search starts at (lastGrant+1) mod N_CH, and lastGrant resets to N_CH-1, so channel 0 has first priority after reset. A grant occurs only when the output stage is loadable (!outValidOut || outReadyIn). lastGrant updates on each grant.
- Output stage: a single register holding type, channel and payload. It loads the granted FIFO head. If no FIFO is non-empty while it is loadable, outValidOut drops.
- Output stability: outValidOut, outTypeOut, outChOut and outDataOut hold stable while outValidOut=1 and outReadyIn=0.
- Flush: flushIn=1 empties all FIFOs and clears outValidOut that cycle. Same-cycle writes are discarded and not counted as drops. lastGrant is unchanged.
- FIFO pointers: log2(DEPTH)-bit read/write pointers wrap naturally. count is log2(DEPTH)+1 bits.

## Timing
- Reset values (rstBIn=0, asynchronous): outValidOut=0, outTypeOut=0, outChOut=0, outDataOut=0, overflowOut=0, dropCntOut=0. All FIFOs are empty and lastGrant=N_CH-1.
- Latency: an event written at edge k into an empty system, with outReadyIn=1, appears with outValidOut=1 after edge k+1 (2 cycles from input strobe to output).
- Throughput: one event per cycle sustained while outReadyIn=1.
- Simultaneous arrivals: all N_CH channels may write in the same cycle. Output order then follows the round-robin rule.
- Reset release: the first write is accepted on the first edge with rstBIn=1.

## Configuration
- BOOK_EVT_DROP_CNT_EN defined: each channel has a 16-bit drop counter, incrementing per dropped event and saturating at 0xFFFF. The counters are presented on dropCntOut and are cleared only by reset; flushIn does not clear them.
- BOOK_EVT_DROP_CNT_EN undefined: no counters are built and dropCntOut is tied to 0. overflowOut still functions.

## Test plan
- Reset, then a single add on ch0 (payload 0x…01) with outReadyIn=1 → outValidOut high 2 cycles after the strobe, for 1 cycle, with outTypeOut=01, outChOut=0 and the payload matching.
- ch0 and ch1 strobe together for 3 cycles (6 events), outReadyIn=1 → output channel order 0,1,0,1,0,1 on consecutive cycles.
- DEPTH=4, outReadyIn=0, 6 events on ch1 → 1 event in the output register plus 4 queued, 1 dropped. overflowOut=1, dropCnt[ch1]=1 (macro on). Release ready → exactly 5 events out, in order.
- outReadyIn=0 with outValidOut=1 for 10 cycles → all output fields constant. On ready, the event is taken once, not duplicated.
- 3 queued events, then flushIn together with a new ch0 strobe → outValidOut=0 next cycle and no events emerge. dropCnt is unchanged.
- 70000 drops on ch0 with the macro on → dropCnt[ch0] saturates at 0xFFFF. With the macro off → dropCntOut=0 throughout.
